// File: rtl/timer_pkg.sv
// timer_pkg: shared definitions for the BCD timer/counter blocks.
//   BCD_W       - width of one BCD digit
//   MAX_DIGITS  - widest counter supported by the helpers below
//   bcd_digit_t - one packed BCD digit
//   to_bcd()    - integer -> packed BCD constant (elaboration-time use only)
//   bcd_valid() - checks a packed BCD word is decimal and below a modulus
package timer_pkg;

  localparam int BCD_W      = 4;
  localparam int MAX_DIGITS = 4;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  // Converts a constant integer to packed BCD, digit 0 in the low nibble.
  // Only ever called with parameter-derived arguments.
  function automatic logic [BCD_W*MAX_DIGITS-1:0] to_bcd(input int value);
    logic [BCD_W*MAX_DIGITS-1:0] r;
    int v;
    r = '0;
    v = value;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      r[i*BCD_W +: BCD_W] = BCD_W'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // True when every used digit is 0..9 and the value is below modulo.
  // Digits above 'digits' are expected to be zero-filled by the caller.
  function automatic logic bcd_valid(input logic [BCD_W*MAX_DIGITS-1:0] val,
                                     input int digits,
                                     input int modulo);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits && val[i*BCD_W +: BCD_W] > 4'd9) ok = 1'b0;
    end
    // Once every digit is decimal, an unsigned compare of the packed
    // words orders them exactly like the decimal numbers they encode.
    if (val > to_bcd(modulo - 1)) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD digit register with increment/decrement and ripple-in.
//   clk, reset - clock, asynchronous active-high reset (digit -> 0)
//   ld, ld_val - synchronous load of a digit value (wins over step)
//   step       - advance this digit on this edge (ripple from lower digits)
//   up         - 1 = increment (9 -> 0), 0 = decrement (0 -> 9)
//   q          - current digit
//   at9, at0   - digit is 9 / digit is 0, used to build the ripple chain
module bcd_digit
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ld,
  input  bcd_digit_t ld_val,
  input  logic       step,
  input  logic       up,
  output bcd_digit_t q,
  output logic       at9,
  output logic       at0
);

  assign at9 = (q == 4'd9);
  assign at0 = (q == 4'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (ld) begin
      q <= ld_val;
    end else if (step) begin
      if (up) q <= at9 ? 4'd0 : q + 4'd1;
      else    q <= at0 ? 4'd9 : q - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: modulo-MODULO up/down counter held as packed BCD.
//   clk, reset - clock, asynchronous active-high reset
//   en, up     - count enable and direction (1 = up)
//   clr        - synchronous clear (highest priority)
//   load       - synchronous parallel load of load_val (BCD, digit 0 low)
//   bcd        - registered count
//   co         - registered one-cycle wrap pulse (carry up / borrow down)
//   tc         - combinational terminal count; drive the next stage's en
//   load_err   - registered one-cycle pulse when a load value is rejected
// Edge priority is clr > load > en.
module bcd_mod_counter
  import timer_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int MODULO = 60
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  input  logic                  load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  output logic [BCD_W*DIGITS-1:0] bcd,
  output logic                  co,
  output logic                  tc,
  output logic                  load_err
);

  localparam int W      = BCD_W * DIGITS;
  localparam int FULL_W = BCD_W * MAX_DIGITS;
  localparam int POW10  = 10 ** DIGITS;

  localparam logic [FULL_W-1:0] MAX_FULL = to_bcd(MODULO - 1);
  localparam logic [W-1:0]      MAX_BCD  = MAX_FULL[W-1:0];

  if (DIGITS < 1 || DIGITS > MAX_DIGITS || MODULO < 2 || MODULO > POW10) begin : g_param_check
    $fatal(1, "bcd_mod_counter: illegal DIGITS/MODULO combination");
  end

  logic [FULL_W-1:0] load_ext;
  logic              load_ok;
  logic              at_term;
  logic              wrap;
  logic              count_step;
  logic              ld_all;
  logic [W-1:0]      ld_word;
  logic [DIGITS-1:0] at9;
  logic [DIGITS-1:0] at0;
  logic [DIGITS-1:0] ripple;

  always_comb begin
    load_ext        = '0;
    load_ext[W-1:0] = load_val;
  end

  assign load_ok = bcd_valid(load_ext, DIGITS, MODULO);

  // Terminal value depends on direction: MODULO-1 going up, 0 going down.
  assign at_term    = up ? (bcd == MAX_BCD) : (bcd == '0);
  assign wrap       = en & at_term;
  assign tc         = wrap & ~clr & ~load;
  assign count_step = en & ~at_term & ~clr & ~load;

  // Clear, load and wrap all reach the digits through their load port;
  // only an ordinary count uses the ripple path.
  assign ld_all = clr | load | wrap;

  always_comb begin
    ld_word = '0;
    if (clr)       ld_word = '0;
    else if (load) ld_word = load_ok ? load_val : '0;
    else if (up)   ld_word = '0;
    else           ld_word = MAX_BCD;
  end

  // Digit i steps only when every lower digit is at its rollover value.
  always_comb begin
    logic acc;
    acc = count_step;
    for (int i = 0; i < DIGITS; i++) begin
      ripple[i] = acc;
      acc       = acc & (up ? at9[i] : at0[i]);
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk    (clk),
      .reset  (reset),
      .ld     (ld_all),
      .ld_val (ld_word[i*BCD_W +: BCD_W]),
      .step   (ripple[i]),
      .up     (up),
      .q      (bcd[i*BCD_W +: BCD_W]),
      .at9    (at9[i]),
      .at0    (at0[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      co       <= 1'b0;
      load_err <= 1'b0;
    end else begin
      co       <= tc;
      load_err <= ~clr & load & ~load_ok;
    end
  end

endmodule

// File: tb/tb_bcd_mod_counter.sv
module tb_bcd_mod_counter;

  localparam int MOD = 60;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main DUT (defaults: 2 digits, modulo 60) ----------------
  logic       en = 0, up = 0, clr = 0, load = 0;
  logic [7:0] load_val = '0;
  logic [7:0] bcd;
  logic       co, tc, load_err;

  bcd_mod_counter u_dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .bcd(bcd), .co(co), .tc(tc), .load_err(load_err)
  );

  // ---------------- cascade: seconds -> minutes ----------------
  logic       c_en = 0, c_up = 1, c_clr = 0, c_load = 0;
  logic [7:0] sec_lv = '0, min_lv = '0;
  logic [7:0] sec_bcd, min_bcd;
  logic       sec_co, min_co, sec_tc, min_tc, sec_err, min_err;

  bcd_mod_counter u_sec (
    .clk(clk), .reset(reset), .en(c_en), .up(c_up), .clr(c_clr), .load(c_load),
    .load_val(sec_lv), .bcd(sec_bcd), .co(sec_co), .tc(sec_tc), .load_err(sec_err)
  );

  bcd_mod_counter u_min (
    .clk(clk), .reset(reset), .en(sec_tc), .up(c_up), .clr(c_clr), .load(c_load),
    .load_val(min_lv), .bcd(min_bcd), .co(min_co), .tc(min_tc), .load_err(min_err)
  );

  // ---------------- modulo-2 single digit ----------------
  logic       m2_en = 0, m2_up = 1, m2_clr = 0, m2_load = 0;
  logic [3:0] m2_lv = '0;
  logic [3:0] m2_bcd;
  logic       m2_co, m2_tc, m2_err;

  bcd_mod_counter #(.DIGITS(1), .MODULO(2)) u_m2 (
    .clk(clk), .reset(reset), .en(m2_en), .up(m2_up), .clr(m2_clr), .load(m2_load),
    .load_val(m2_lv), .bcd(m2_bcd), .co(m2_co), .tc(m2_tc), .load_err(m2_err)
  );

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of u_dut ----------------
  // Count kept as a plain integer; BCD is only an encoding for comparison.
  int         m_val = 0;
  logic       m_co  = 0;
  logic       m_err = 0;
  logic [9:0] exp_q[$];   // {bcd, co, load_err} expected after each edge

  function automatic logic [7:0] enc(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic int dec(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic is_valid(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (dec(b) < MOD);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_val = 0;
      m_co  = 0;
      m_err = 0;
      exp_q.delete();
    end else begin
      m_co  = 0;
      m_err = 0;
      if (clr) begin
        m_val = 0;
      end else if (load) begin
        if (is_valid(load_val)) m_val = dec(load_val);
        else begin
          m_val = 0;
          m_err = 1;
        end
      end else if (en) begin
        if (up) begin
          m_val = m_val + 1;
          if (m_val == MOD) begin
            m_val = 0;
            m_co  = 1;
          end
        end else if (m_val == 0) begin
          m_val = MOD - 1;
          m_co  = 1;
        end else begin
          m_val = m_val - 1;
        end
      end
      exp_q.push_back({enc(m_val), m_co, m_err});
    end
  end

  // ---------------- scoreboard compare (falling edge) ----------------
  always @(negedge clk) begin
    logic [9:0] e;
    logic       exp_tc;
    if (!reset) begin
      exp_tc = en && !clr && !load && (up ? (m_val == MOD - 1) : (m_val == 0));
      check("sb_tc", 32'(tc), 32'(exp_tc));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_bcd", 32'(bcd), 32'(e[9:2]));
        check("sb_co", 32'(co), 32'(e[1]));
        check("sb_load_err", 32'(load_err), 32'(e[0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change 2 time units after a rising edge; tick returns at the
  // same offset after the next edge, so outputs are settled on return.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic e, input logic u, input logic c,
                       input logic l, input logic [7:0] lv);
    en = e; up = u; clr = c; load = l; load_val = lv;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    // reset state
    #12;
    check("reset_bcd", 32'(bcd), 32'h00);
    check("reset_co", 32'(co), 32'h0);
    check("reset_err", 32'(load_err), 32'h0);
    check("reset_tc", 32'(tc), 32'h0);
    @(posedge clk); #2;
    reset = 1'b0;

    // full up sequence 00..59 then wrap
    drive(1, 1, 0, 0, 8'h00);
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (i == 1)  check("up_first", 32'(bcd), 32'h01);
      if (i == 10) check("up_ripple", 32'(bcd), 32'h10);
      if (i == 58) check("up_tc_low", 32'(tc), 32'h0);
      if (i == 59) begin
        check("up_59", 32'(bcd), 32'h59);
        check("up_tc_59", 32'(tc), 32'h1);
        check("up_co_59", 32'(co), 32'h0);
      end
      if (i == 60) begin
        check("up_wrap_bcd", 32'(bcd), 32'h00);
        check("up_wrap_co", 32'(co), 32'h1);
      end
    end
    drive(0, 1, 0, 0, 8'h00);
    tick();
    check("co_one_cycle", 32'(co), 32'h0);

    // down from 00 wraps to 59
    drive(0, 0, 0, 1, 8'h00);
    tick();
    check("load00", 32'(bcd), 32'h00);
    drive(1, 0, 0, 0, 8'h00);
    tick();
    check("dn_wrap_bcd", 32'(bcd), 32'h59);
    check("dn_wrap_co", 32'(co), 32'h1);
    tick();
    check("dn_58", 32'(bcd), 32'h58);
    check("dn_58_co", 32'(co), 32'h0);
    tick();
    check("dn_57", 32'(bcd), 32'h57);

    // load validation
    drive(0, 1, 0, 1, 8'h45); tick();
    check("load45", 32'(bcd), 32'h45);
    check("load45_err", 32'(load_err), 32'h0);
    drive(0, 1, 0, 1, 8'h6A); tick();
    check("load6A", 32'(bcd), 32'h00);
    check("load6A_err", 32'(load_err), 32'h1);
    drive(0, 1, 0, 0, 8'h00); tick();
    check("err_one_cycle", 32'(load_err), 32'h0);
    drive(0, 1, 0, 1, 8'h72); tick();
    check("load72", 32'(bcd), 32'h00);
    check("load72_err", 32'(load_err), 32'h1);
    drive(0, 1, 0, 1, 8'h59); tick();
    check("load59", 32'(bcd), 32'h59);
    check("load59_err", 32'(load_err), 32'h0);
    drive(0, 1, 0, 1, 8'h60); tick();
    check("load60", 32'(bcd), 32'h00);
    check("load60_err", 32'(load_err), 32'h1);

    // priority: clr > load > en
    drive(0, 1, 0, 1, 8'h37); tick();
    check("load37", 32'(bcd), 32'h37);
    drive(1, 1, 1, 1, 8'h45); #1;
    check("prio_tc", 32'(tc), 32'h0);
    tick();
    check("prio_bcd", 32'(bcd), 32'h00);
    check("prio_co", 32'(co), 32'h0);
    check("prio_err", 32'(load_err), 32'h0);
    drive(0, 1, 1, 1, 8'h6A); tick();
    check("clr_masks_err", 32'(load_err), 32'h0);
    drive(0, 1, 0, 1, 8'h59); tick();
    drive(1, 1, 0, 1, 8'h12); #1;
    check("load_masks_tc", 32'(tc), 32'h0);
    tick();
    check("load_beats_wrap", 32'(bcd), 32'h12);
    check("load_beats_wrap_co", 32'(co), 32'h0);

    // asynchronous reset mid-count
    drive(0, 1, 0, 1, 8'h22); tick();
    drive(1, 1, 0, 0, 8'h00); tick();
    #1;
    check("pre_reset_23", 32'(bcd), 32'h23);
    reset = 1'b1;
    #1;
    check("async_reset_bcd", 32'(bcd), 32'h00);
    check("async_reset_co", 32'(co), 32'h0);
    tick();
    reset = 1'b0;
    tick();
    check("after_reset_01", 32'(bcd), 32'h01);
    drive(0, 1, 0, 0, 8'h00);

    // cascade 00:59 -> 01:00
    c_load = 1; sec_lv = 8'h59; min_lv = 8'h00; c_en = 0;
    tick();
    check("casc_load_sec", 32'(sec_bcd), 32'h59);
    check("casc_load_min", 32'(min_bcd), 32'h00);
    c_load = 0; c_en = 1; #1;
    check("casc_sec_tc", 32'(sec_tc), 32'h1);
    tick();
    check("casc1_sec", 32'(sec_bcd), 32'h00);
    check("casc1_min", 32'(min_bcd), 32'h01);
    check("casc1_sec_co", 32'(sec_co), 32'h1);
    check("casc1_min_co", 32'(min_co), 32'h0);
    // cascade 59:59 -> 00:00
    c_en = 0; c_load = 1; sec_lv = 8'h59; min_lv = 8'h59;
    tick();
    c_load = 0; c_en = 1;
    tick();
    check("casc2_sec", 32'(sec_bcd), 32'h00);
    check("casc2_min", 32'(min_bcd), 32'h00);
    check("casc2_sec_co", 32'(sec_co), 32'h1);
    check("casc2_min_co", 32'(min_co), 32'h1);
    c_en = 0;
    tick();
    check("casc_co_clear", 32'({sec_co, min_co}), 32'h0);

    // modulo 2: wrap on every other edge with en held
    m2_en = 1;
    tick();
    check("m2_e1_bcd", 32'(m2_bcd), 32'h1);
    check("m2_e1_co", 32'(m2_co), 32'h0);
    tick();
    check("m2_e2_bcd", 32'(m2_bcd), 32'h0);
    check("m2_e2_co", 32'(m2_co), 32'h1);
    tick();
    check("m2_e3_co", 32'(m2_co), 32'h0);
    tick();
    check("m2_e4_co", 32'(m2_co), 32'h1);
    m2_en = 0;

    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- run-time bound ----------------
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
